// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier control path.
// Holds the FSM state enum, Booth window codes and the window-to-strobe lookup.
package mult_pkg;

    localparam int STEPS_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Booth windows {b[i+1], b[i], b[i-1]}; each of 0, +1 and -1 has two encodings.
    localparam logic [2:0] BOOTH_Z   = 3'b000;
    localparam logic [2:0] BOOTH_P1  = 3'b001;
    localparam logic [2:0] BOOTH_P1B = 3'b010;
    localparam logic [2:0] BOOTH_P2  = 3'b011;
    localparam logic [2:0] BOOTH_M2  = 3'b100;
    localparam logic [2:0] BOOTH_M1  = 3'b101;
    localparam logic [2:0] BOOTH_M1B = 3'b110;
    localparam logic [2:0] BOOTH_ZB  = 3'b111;

    typedef struct packed {
        logic add;
        logic sub;
        logic shift_mcand;
        logic nop;
    } booth_ctl_t;

    function automatic booth_ctl_t booth_lookup(input logic [2:0] win);
        booth_ctl_t ctl;
        ctl = '0;
        unique case (win)
            BOOTH_Z, BOOTH_ZB:   ctl.nop = 1'b1;
            BOOTH_P1, BOOTH_P1B: ctl.add = 1'b1;
            BOOTH_P2:            begin ctl.add = 1'b1; ctl.shift_mcand = 1'b1; end
            BOOTH_M2:            begin ctl.sub = 1'b1; ctl.shift_mcand = 1'b1; end
            BOOTH_M1, BOOTH_M1B: ctl.sub = 1'b1;
            default:             ctl.nop = 1'b1;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mult_control_if.sv
// Strobe bundle between the multiplier datapath (master) and mult_control (slave).
interface mult_control_if;
    logic       start;
    logic [2:0] data_in;
    logic       add;
    logic       sub;
    logic       shiftMultiplicand;
    logic       shiftProduct;
    logic       nop;
    logic       ready;

    modport master (
        output start, data_in,
        input  add, sub, shiftMultiplicand, shiftProduct, nop, ready
    );

    modport slave (
        input  start, data_in,
        output add, sub, shiftMultiplicand, shiftProduct, nop, ready
    );
endinterface

// File: rtl/mult_control_booth_decode.sv
// Combinational Booth window decoder; all strobes are forced low when not enabled.
module booth_decode
    import mult_pkg::*;
(
    input  logic       en,
    input  logic [2:0] data_in,
    output booth_ctl_t ctl
);

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        ctl = '0;
        if (en) begin
            ctl = booth_lookup(data_in);
        end
    end

endmodule

// File: rtl/mult_control.sv
// Iteration FSM for the radix-4 Booth multiplier: counts STEPS shifts, then raises ready.
// Optional MULT_CONTROL_BUSY_EN adds a `busy` output that is high while iterating.
module mult_control
    import mult_pkg::*;
#(
    parameter int STEPS = STEPS_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    mult_control_if.slave        bus
`ifdef MULT_CONTROL_BUSY_EN
    ,
    output logic                 busy
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             ready_q, ready_d;
    booth_ctl_t       ctl;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // A start during RUN abandons the current product and begins again.
                if (bus.start) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        run_d   = (state_d == ST_RUN);
        ready_d = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            ready_q <= ready_d;
        end
    end

    booth_decode u_decode (
        .en      (run_q),
        .data_in (bus.data_in),
        .ctl     (ctl)
    );

    assign bus.add               = ctl.add;
    assign bus.sub               = ctl.sub;
    assign bus.shiftMultiplicand = ctl.shift_mcand;
    assign bus.nop               = ctl.nop;
    assign bus.shiftProduct      = run_q;
    assign bus.ready             = ready_q;

`ifdef MULT_CONTROL_BUSY_EN
    assign busy = run_q;
`endif

endmodule

// File: tb/tb_mult_control.sv
// Directed scoreboard bench for mult_control; also checks `busy` when built with
// MULT_CONTROL_BUSY_EN.
module tb_mult_control;

    typedef enum logic [1:0] {PH_IDLE, PH_RUN, PH_DONE} phase_e;

    typedef struct packed {
        logic add;
        logic sub;
        logic sm;
        logic sp;
        logic nop;
        logic ready;
        logic busy;
    } obs_t;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   sp_count = 0;
    obs_t obs;
    obs_t exp_q[$];
    logic busy_w;

    always #5 clock = ~clock;

    mult_control_if bus ();

    mult_control #(.STEPS(16), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MULT_CONTROL_BUSY_EN
        ,
        .busy  (busy_w)
`endif
    );

`ifndef MULT_CONTROL_BUSY_EN
    assign busy_w = 1'b0;
`endif

    always_comb begin
        obs = '{bus.add, bus.sub, bus.shiftMultiplicand, bus.shiftProduct,
                bus.nop, bus.ready, busy_w};
    end

    function automatic obs_t exp_for(input phase_e ph, input logic [2:0] w);
        obs_t e;
        e = '0;
        if (ph == PH_RUN) begin
            e.sp = 1'b1;
            case (w)
                3'b000, 3'b111: e.nop = 1'b1;
                3'b001, 3'b010: e.add = 1'b1;
                3'b011:         begin e.add = 1'b1; e.sm = 1'b1; end
                3'b100:         begin e.sub = 1'b1; e.sm = 1'b1; end
                default:        e.sub = 1'b1;
            endcase
`ifdef MULT_CONTROL_BUSY_EN
            e.busy = 1'b1;
`endif
        end
        if (ph == PH_DONE) e.ready = 1'b1;
        return e;
    endfunction

    task automatic check_front(input string tag);
        obs_t e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (add sub sm sp nop ready busy)", tag, obs, e);
        end
        if (obs.sp === 1'b1) sp_count++;
    endtask

    // Drive the window, compare this cycle's outputs, then advance one edge.
    task automatic step(input string tag, input phase_e ph, input logic [2:0] w);
        bus.data_in = w;
        #1;
        exp_q.push_back(exp_for(ph, w));
        check_front(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 3'b011;
        repeat (2) @(posedge clock);
        #1;
        step("reset_zero", PH_IDLE, 3'b011);

        // Reset must win over a simultaneous start.
        bus.start = 1'b1;
        step("reset_hold", PH_IDLE, 3'b100);
        reset     = 1'b0;
        bus.start = 1'b0;
        step("reset_prio", PH_IDLE, 3'b001);
        step("idle_quiet", PH_IDLE, 3'b101);

        // Decode sweep followed by the full latency run.
        bus.start = 1'b1;
        step("idle_start", PH_IDLE, 3'b010);
        bus.start = 1'b0;
        sp_count  = 0;
        for (int i = 0; i < 8; i++) step("sweep", PH_RUN, 3'(i));
        for (int i = 8; i < 16; i++) step("run_tail", PH_RUN, 3'($urandom));
        for (int i = 0; i < 22; i++) step("done_hold", PH_DONE, 3'($urandom));
        check_count("sp_pulses", sp_count, 16);

        // Restart at iteration 7 of a run.
        bus.start = 1'b1;
        step("done_start", PH_DONE, 3'b011);
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step("run_a", PH_RUN, 3'($urandom));
        bus.start = 1'b1;
        step("run_restart", PH_RUN, 3'b100);
        bus.start = 1'b0;
        sp_count  = 0;
        for (int i = 0; i < 16; i++) step("run_b", PH_RUN, 3'($urandom));
        check_count("sp_after_restart", sp_count, 16);

        // Back-to-back: start in the first DONE cycle.
        bus.start = 1'b1;
        step("done_b2b", PH_DONE, 3'b110);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step("run_c", PH_RUN, 3'($urandom));
        reset = 1'b1;
        step("run_reset", PH_RUN, 3'b001);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) step("after_reset", PH_IDLE, 3'($urandom));

        check_count("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
